// File: rtl/fragment_buffer_fetch_pkg.sv
// Shared widths and hazard-window depth for the fragment buffer fetch stage.
package fragment_buffer_fetch_pkg;
  localparam int FB_INDEX_WIDTH_DEF   = 14;
  localparam int SCREEN_POS_WIDTH_DEF = 16;
  localparam int DEPTH_WIDTH_DEF      = 16;
  localparam int STENCIL_WIDTH_DEF    = 4;
  localparam int PIXEL_WIDTH_DEF      = 32;
  localparam int FRAG_DEPTH_WIDTH     = 32;
  localparam int STALL_COUNT_WIDTH    = 16;

  // Per-fragment pipeline depth plus its write-back stage.
  localparam int DOWNSTREAM_DEPTH     = 4;
  localparam int HAZARD_WINDOW_DEF    = DOWNSTREAM_DEPTH + 1;

  function automatic logic [STALL_COUNT_WIDTH-1:0] sat_inc(input logic [STALL_COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/fragment_buffer_fetch_scoreboard.sv
// In-flight framebuffer index tracker: shift register with a parallel compare against the probe index.
module fragment_hazard_scoreboard #(
  parameter int INDEX_WIDTH = 14,
  parameter int WINDOW      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   push,
  input  logic [INDEX_WIDTH-1:0] index,
  output logic                   hazard
);
  logic [WINDOW-1:0]      slot_valid;
  logic [INDEX_WIDTH-1:0] slot_index [WINDOW];
  logic [WINDOW-1:0]      match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
    end else if (ce) begin
      slot_valid <= {slot_valid[WINDOW-2:0], push};
    end
  end

  // Index slots carry no reset; a slot's valid bit alone qualifies it.
  always_ff @(posedge clk) begin
    if (ce) begin
      slot_index[0] <= index;
      for (int i = 1; i < WINDOW; i++) begin
        slot_index[i] <= slot_index[i-1];
      end
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < WINDOW; i++) begin
      match[i] = slot_valid[i] && (slot_index[i] == index);
    end
  end

  assign hazard = |match;
endmodule

// File: rtl/fragment_buffer_fetch.sv
// Issues color/depth/stencil reads per fragment and re-presents the fragment one ce-cycle later with the data.
// Optional read-after-write hazard scoreboard and stall counter built when FRAGMENT_HAZARD_CHECK_EN is defined.
module fragment_buffer_fetch
  import fragment_buffer_fetch_pkg::*;
#(
  parameter int FRAMEBUFFER_INDEX_WIDTH = FB_INDEX_WIDTH_DEF,
  parameter int SCREEN_POS_WIDTH        = SCREEN_POS_WIDTH_DEF,
  parameter int DEPTH_WIDTH             = DEPTH_WIDTH_DEF,
  parameter int STENCIL_WIDTH           = STENCIL_WIDTH_DEF,
  parameter int PIXEL_WIDTH             = PIXEL_WIDTH_DEF,
  parameter int HAZARD_WINDOW           = HAZARD_WINDOW_DEF
) (
  input  logic                               aclk,
  input  logic                               reset,
  input  logic                               s_frag_tvalid,
  output logic                               s_frag_tready,
  input  logic                               s_frag_tlast,
  input  logic                               s_frag_tkeep,
  input  logic [PIXEL_WIDTH-1:0]             s_frag_tcolor,
  input  logic [FRAG_DEPTH_WIDTH-1:0]        s_frag_tdepth,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s_frag_tindex,
  input  logic [SCREEN_POS_WIDTH-1:0]        s_frag_tscreenPosX,
  input  logic [SCREEN_POS_WIDTH-1:0]        s_frag_tscreenPosY,
  output logic [FRAMEBUFFER_INDEX_WIDTH-1:0] rd_addr,
  output logic                               rd_en,
  input  logic [PIXEL_WIDTH-1:0]             rd_color,
  input  logic [DEPTH_WIDTH-1:0]             rd_depth,
  input  logic [STENCIL_WIDTH-1:0]           rd_stencil,
  output logic                               m_frag_tvalid,
  input  logic                               m_frag_tready,
  output logic                               m_frag_tlast,
  output logic                               m_frag_tkeep,
  output logic [PIXEL_WIDTH-1:0]             m_frag_tcolor,
  output logic [FRAG_DEPTH_WIDTH-1:0]        m_frag_tdepth,
  output logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_frag_tindex,
  output logic [SCREEN_POS_WIDTH-1:0]        m_frag_tscreenPosX,
  output logic [SCREEN_POS_WIDTH-1:0]        m_frag_tscreenPosY,
  output logic [PIXEL_WIDTH-1:0]             m_frag_color_tdata,
  output logic [DEPTH_WIDTH-1:0]             m_frag_depth_tdata,
  output logic [STENCIL_WIDTH-1:0]           m_frag_stencil_tdata,
  output logic [STALL_COUNT_WIDTH-1:0]       stall_count,
  input  logic                               stall_count_clear
);
  logic ce;
  logic hazard;
  logic accept;

  // Downstream ready doubles as the clock enable of the whole pipeline.
  assign ce            = m_frag_tready;
  assign s_frag_tready = m_frag_tready & ~hazard;
  assign accept        = s_frag_tvalid & s_frag_tready;
  assign rd_addr       = s_frag_tindex;
  assign rd_en         = ce;

`ifdef FRAGMENT_HAZARD_CHECK_EN
  logic sb_hit;

  fragment_hazard_scoreboard #(
    .INDEX_WIDTH (FRAMEBUFFER_INDEX_WIDTH),
    .WINDOW      (HAZARD_WINDOW)
  ) u_scoreboard (
    .clk    (aclk),
    .rst    (reset),
    .ce     (ce),
    .push   (accept & s_frag_tkeep),
    .index  (s_frag_tindex),
    .hazard (sb_hit)
  );

  assign hazard = s_frag_tvalid & s_frag_tkeep & sb_hit;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_count_clear) begin
      stall_count <= '0;
    end else if (ce && hazard) begin
      stall_count <= sat_inc(stall_count);
    end
  end
`else
  localparam int unused_window = HAZARD_WINDOW;
  logic unused_clear;

  assign unused_clear = stall_count_clear;
  assign hazard       = 1'b0;
  assign stall_count  = '0;
`endif

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      m_frag_tvalid <= 1'b0;
      m_frag_tlast  <= 1'b0;
      m_frag_tkeep  <= 1'b0;
    end else if (ce) begin
      m_frag_tvalid <= accept;
      m_frag_tlast  <= s_frag_tlast;
      m_frag_tkeep  <= s_frag_tkeep;
    end
  end

  always_ff @(posedge aclk) begin
    if (ce) begin
      m_frag_tcolor      <= s_frag_tcolor;
      m_frag_tdepth      <= s_frag_tdepth;
      m_frag_tindex      <= s_frag_tindex;
      m_frag_tscreenPosX <= s_frag_tscreenPosX;
      m_frag_tscreenPosY <= s_frag_tscreenPosY;
    end
  end

  // Buffer read data lands in the same cycle as the registered fragment.
  assign m_frag_color_tdata   = rd_color;
  assign m_frag_depth_tdata   = rd_depth;
  assign m_frag_stencil_tdata = rd_stencil;
endmodule

// File: tb/tb_fragment_buffer_fetch.sv
// Directed and randomized checks of fragment_buffer_fetch against a history-queue reference model.
module tb_fragment_buffer_fetch;
  import fragment_buffer_fetch_pkg::*;

  localparam int IW  = 14;
  localparam int PW  = 32;
  localparam int DW  = 16;
  localparam int SW  = 4;
  localparam int SPW = 16;
  localparam int HW  = 5;
`ifdef FRAGMENT_HAZARD_CHECK_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif
  localparam int EXP_PAIR_STALL = HAZ_EN ? HW : 0;

  logic           aclk = 1'b0;
  logic           reset;
  logic           s_frag_tvalid, s_frag_tready, s_frag_tlast, s_frag_tkeep;
  logic [PW-1:0]  s_frag_tcolor;
  logic [31:0]    s_frag_tdepth;
  logic [IW-1:0]  s_frag_tindex;
  logic [SPW-1:0] s_frag_tscreenPosX, s_frag_tscreenPosY;
  logic [IW-1:0]  rd_addr;
  logic           rd_en;
  logic [PW-1:0]  rd_color;
  logic [DW-1:0]  rd_depth;
  logic [SW-1:0]  rd_stencil;
  logic           m_frag_tvalid, m_frag_tready, m_frag_tlast, m_frag_tkeep;
  logic [PW-1:0]  m_frag_tcolor;
  logic [31:0]    m_frag_tdepth;
  logic [IW-1:0]  m_frag_tindex;
  logic [SPW-1:0] m_frag_tscreenPosX, m_frag_tscreenPosY;
  logic [PW-1:0]  m_frag_color_tdata;
  logic [DW-1:0]  m_frag_depth_tdata;
  logic [SW-1:0]  m_frag_stencil_tdata;
  logic [15:0]    stall_count;
  logic           stall_count_clear;

  fragment_buffer_fetch dut (
    .aclk(aclk), .reset(reset),
    .s_frag_tvalid(s_frag_tvalid), .s_frag_tready(s_frag_tready),
    .s_frag_tlast(s_frag_tlast), .s_frag_tkeep(s_frag_tkeep),
    .s_frag_tcolor(s_frag_tcolor), .s_frag_tdepth(s_frag_tdepth),
    .s_frag_tindex(s_frag_tindex),
    .s_frag_tscreenPosX(s_frag_tscreenPosX), .s_frag_tscreenPosY(s_frag_tscreenPosY),
    .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_color(rd_color), .rd_depth(rd_depth), .rd_stencil(rd_stencil),
    .m_frag_tvalid(m_frag_tvalid), .m_frag_tready(m_frag_tready),
    .m_frag_tlast(m_frag_tlast), .m_frag_tkeep(m_frag_tkeep),
    .m_frag_tcolor(m_frag_tcolor), .m_frag_tdepth(m_frag_tdepth),
    .m_frag_tindex(m_frag_tindex),
    .m_frag_tscreenPosX(m_frag_tscreenPosX), .m_frag_tscreenPosY(m_frag_tscreenPosY),
    .m_frag_color_tdata(m_frag_color_tdata), .m_frag_depth_tdata(m_frag_depth_tdata),
    .m_frag_stencil_tdata(m_frag_stencil_tdata),
    .stall_count(stall_count), .stall_count_clear(stall_count_clear)
  );

  always #5 aclk = ~aclk;

  // Buffer contents are a fixed function of the address.
  function automatic logic [PW-1:0] fcolor(input logic [IW-1:0] a);
    return {2'b10, a, ~a, 2'b01};
  endfunction
  function automatic logic [DW-1:0] fdepth(input logic [IW-1:0] a);
    return {2'b01, a};
  endfunction
  function automatic logic [SW-1:0] fsten(input logic [IW-1:0] a);
    return a[3:0] ^ 4'h5;
  endfunction

  always @(posedge aclk) begin
    if (rd_en) begin
      rd_color   <= fcolor(rd_addr);
      rd_depth   <= fdepth(rd_addr);
      rd_stencil <= fsten(rd_addr);
    end
  end

  // Reference model: indices of kept fragments accepted in the last HW ce-cycles.
  int             hist[$];
  bit             exp_valid, exp_last, exp_keep;
  logic [PW-1:0]  exp_color;
  logic [31:0]    exp_depth;
  logic [IW-1:0]  exp_index;
  logic [SPW-1:0] exp_x, exp_y;
  int             exp_cnt;
  bit             obs_rdy;
  int             n_cmp = 0;
  int             n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_hist(input int idx);
    foreach (hist[i]) if (hist[i] == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < HW; i++) hist.push_back(-1);
    exp_valid = 0; exp_last = 0; exp_keep = 0; exp_cnt = 0;
  endtask

  task automatic drive(input bit v, input bit keep, input bit last, input int idx);
    s_frag_tvalid      = v;
    s_frag_tkeep       = keep;
    s_frag_tlast       = last;
    s_frag_tindex      = IW'(idx);
    s_frag_tcolor      = $urandom;
    s_frag_tdepth      = $urandom;
    s_frag_tscreenPosX = SPW'($urandom);
    s_frag_tscreenPosY = SPW'($urandom);
  endtask

  task automatic step();
    bit hz, rdy, acc;
    #1;
    hz  = HAZ_EN && s_frag_tvalid && s_frag_tkeep && in_hist(int'(s_frag_tindex));
    rdy = m_frag_tready && !hz;
    acc = s_frag_tvalid && rdy;
    obs_rdy = s_frag_tready;
    check("s_tready", 64'(s_frag_tready), 64'(rdy));
    check("rd_addr", 64'(rd_addr), 64'(s_frag_tindex));
    check("rd_en", 64'(rd_en), 64'(m_frag_tready));
    @(posedge aclk);
    if (stall_count_clear) exp_cnt = 0;
    else if (m_frag_tready && hz && exp_cnt < 65535) exp_cnt++;
    if (m_frag_tready) begin
      hist.push_front((acc && s_frag_tkeep) ? int'(s_frag_tindex) : -1);
      void'(hist.pop_back());
      exp_valid = acc;
      exp_last  = s_frag_tlast;
      exp_keep  = s_frag_tkeep;
      exp_color = s_frag_tcolor;
      exp_depth = s_frag_tdepth;
      exp_index = s_frag_tindex;
      exp_x     = s_frag_tscreenPosX;
      exp_y     = s_frag_tscreenPosY;
    end
    #1;
    check("m_tvalid", 64'(m_frag_tvalid), 64'(exp_valid));
    check("m_tlast", 64'(m_frag_tlast), 64'(exp_last));
    check("m_tkeep", 64'(m_frag_tkeep), 64'(exp_keep));
    check("stall_count", 64'(stall_count), 64'(exp_cnt));
    if (exp_valid) begin
      check("m_tcolor", 64'(m_frag_tcolor), 64'(exp_color));
      check("m_tdepth", 64'(m_frag_tdepth), 64'(exp_depth));
      check("m_tindex", 64'(m_frag_tindex), 64'(exp_index));
      check("m_tposx", 64'(m_frag_tscreenPosX), 64'(exp_x));
      check("m_tposy", 64'(m_frag_tscreenPosY), 64'(exp_y));
      check("color_tdata", 64'(m_frag_color_tdata), 64'(fcolor(exp_index)));
      check("depth_tdata", 64'(m_frag_depth_tdata), 64'(fdepth(exp_index)));
      check("stencil_tdata", 64'(m_frag_stencil_tdata), 64'(fsten(exp_index)));
    end
  endtask

  task automatic flush();
    drive(0, 0, 0, 0);
    repeat (HW + 1) step();
  endtask

  initial begin
    int stalls;
    logic [PW-1:0] hold_color, hold_rd;
    logic [15:0]   hold_cnt;

    reset = 1'b1;
    m_frag_tready = 1'b1;
    stall_count_clear = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    check("rst_tvalid", 64'(m_frag_tvalid), 64'(0));
    check("rst_tlast", 64'(m_frag_tlast), 64'(0));
    check("rst_tkeep", 64'(m_frag_tkeep), 64'(0));
    check("rst_stall_count", 64'(stall_count), 64'(0));
    reset = 1'b0;

    // Back-to-back distinct indices.
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, i == 9, i);
      step();
      check("seq_accept", 64'(obs_rdy), 64'(1));
    end
    flush();
    check("seq_stall_count", 64'(stall_count), 64'(0));

    // Same index back-to-back.
    drive(1, 1, 0, 7);
    step();
    drive(1, 1, 1, 7);
    stalls = 0;
    do begin
      step();
      if (!obs_rdy) stalls++;
    end while (!obs_rdy && stalls < 20);
    check("pair_stall_cycles", 64'(stalls), 64'(EXP_PAIR_STALL));
    check("pair_stall_count", 64'(stall_count), 64'(EXP_PAIR_STALL));
    flush();

    // Same index after the window has fully aged out.
    stalls = 0;
    drive(1, 1, 0, 7);
    step();
    for (int i = 1; i <= HW; i++) begin
      drive(1, 1, 0, i);
      step();
      if (!obs_rdy) stalls++;
    end
    drive(1, 1, 0, 7);
    step();
    if (!obs_rdy) stalls++;
    check("aged_stalls", 64'(stalls), 64'(0));
    flush();

    // Dropped fragment never enters the scoreboard but still passes through.
    drive(1, 0, 1, 7);
    step();
    check("keep0_tkeep", 64'(m_frag_tkeep), 64'(0));
    check("keep0_tlast", 64'(m_frag_tlast), 64'(1));
    drive(1, 1, 0, 7);
    step();
    check("keep0_no_stall", 64'(obs_rdy), 64'(1));
    flush();

    // Downstream backpressure holds everything.
    for (int i = 20; i < 23; i++) begin
      drive(1, 1, 0, i);
      step();
    end
    hold_color = m_frag_tcolor;
    hold_rd    = m_frag_color_tdata;
    hold_cnt   = stall_count;
    m_frag_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 30 + i);
      step();
      check("bp_hold_color", 64'(m_frag_tcolor), 64'(hold_color));
      check("bp_hold_rd", 64'(m_frag_color_tdata), 64'(hold_rd));
      check("bp_hold_cnt", 64'(stall_count), 64'(hold_cnt));
    end
    m_frag_tready = 1'b1;
    step();
    flush();

    // Reset in the middle of a stall.
    drive(1, 1, 0, 7);
    step();
    drive(1, 1, 0, 7);
    step();
    reset = 1'b1;
    #1;
    check("rst_mid_tvalid", 64'(m_frag_tvalid), 64'(0));
    check("rst_mid_count", 64'(stall_count), 64'(0));
    model_reset();
    @(posedge aclk);
    #1;
    reset = 1'b0;
    drive(1, 1, 0, 7);
    step();
    check("rst_mid_accept", 64'(obs_rdy), 64'(1));
    flush();

    // Randomized traffic over a small index range to provoke hazards.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)));
      m_frag_tready     = $urandom_range(0, 4) != 0;
      stall_count_clear = $urandom_range(0, 40) == 0;
      step();
    end
    m_frag_tready = 1'b1;
    stall_count_clear = 1'b0;
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
